// File: rtl/bus_source_encoder_pkg.sv
// Shared types and constants for the bus source-select encoder.
//   enc_state_e  : encoder FSM state (empty / driving / holding)
//   req_class_e  : request-vector classification by popcount
//   ERR_CNT_W    : width of the multi-drive error counter
//   ERR_CNT_MAX  : saturation value of the error counter
//   err_cnt_inc  : saturating increment helper
package bus_enc_pkg;

    typedef enum logic [1:0] {
        StEmpty,
        StDrive,
        StHold
    } enc_state_e;

    typedef enum logic [1:0] {
        ClsZero,
        ClsOne,
        ClsMulti
    } req_class_e;

    localparam int unsigned ERR_CNT_W = 8;
    localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = 8'd255;

    function automatic logic [ERR_CNT_W-1:0] err_cnt_inc(input logic [ERR_CNT_W-1:0] cnt);
        return (cnt == ERR_CNT_MAX) ? cnt : cnt + 8'd1;
    endfunction

endpackage

// File: rtl/bus_source_encoder_if.sv
// Request/status bundle between the bus requesters and the source encoder.
//   req        : per-source drive requests (bit k = source k)
//   prio_mode  : 0 = strict one-hot, 1 = lowest index wins
//   err_clr    : clears the sticky error flag and the error counter
//   idx        : registered bus select
//   valid      : idx comes from a legal request in this update
//   hold       : idx retained from an earlier update
//   multi_err  : one-cycle pulse on a strict-mode multi-drive
//   err_sticky : latched multi-drive flag
//   err_count  : saturating count of multi-drive events
// master = requester side, slave = encoder side.
interface bus_source_encoder_if
    import bus_enc_pkg::*;
#(
    parameter int unsigned N_SRC = 32,
    parameter int unsigned IDX_W = $clog2(N_SRC)
) ();

    logic [N_SRC-1:0]     req;
    logic                 prio_mode;
    logic                 err_clr;
    logic [IDX_W-1:0]     idx;
    logic                 valid;
    logic                 hold;
    logic                 multi_err;
    logic                 err_sticky;
    logic [ERR_CNT_W-1:0] err_count;

    modport master (
        output req, prio_mode, err_clr,
        input  idx, valid, hold, multi_err, err_sticky, err_count
    );

    modport slave (
        input  req, prio_mode, err_clr,
        output idx, valid, hold, multi_err, err_sticky, err_count
    );

endinterface

// File: rtl/lsb_index_finder.sv
// Combinational lowest-set-bit finder and request classifier.
//   req       : request vector
//   lsb_idx   : index of the lowest set bit (0 when req is zero)
//   req_class : ClsZero / ClsOne / ClsMulti by popcount of req
module lsb_index_finder
    import bus_enc_pkg::*;
#(
    parameter int unsigned N_SRC = 32,
    parameter int unsigned IDX_W = $clog2(N_SRC)
) (
    input  logic [N_SRC-1:0] req,
    output logic [IDX_W-1:0] lsb_idx,
    output req_class_e       req_class
);

    logic seen;
    logic multi;

    always_comb begin
        lsb_idx = '0;
        seen    = 1'b0;
        multi   = 1'b0;
        for (int unsigned k = 0; k < N_SRC; k++) begin
            if (req[k]) begin
                if (!seen) begin
                    lsb_idx = IDX_W'(k);
                end else begin
                    multi = 1'b1;
                end
                seen = 1'b1;
            end
        end
    end

    always_comb begin
        if (!seen) begin
            req_class = ClsZero;
        end else if (multi) begin
            req_class = ClsMulti;
        end else begin
            req_class = ClsOne;
        end
    end

endmodule

// File: rtl/bus_source_encoder.sv
// Registered source-select encoder for the datapath bus. Turns per-source drive
// requests into the binary index steering the bus mux, with valid/hold status,
// strict or priority arbitration and multi-drive error tracking.
//   clk : system clock, rising edge
//   clr : synchronous active-high reset, overrides everything
//   bus : slave side of bus_source_encoder_if (req/prio_mode/err_clr in,
//         idx/valid/hold/multi_err/err_sticky/err_count out)
// STAGES=1: outputs update on the edge that samples req.
// STAGES=2: req/prio_mode are registered first, outputs update one edge later.
module bus_source_encoder
    import bus_enc_pkg::*;
#(
    parameter int unsigned N_SRC     = 32,
    parameter int unsigned IDX_W     = $clog2(N_SRC),
    parameter int unsigned STAGES    = 1,
    parameter int unsigned RESET_IDX = 0
) (
    input logic           clk,
    input logic           clr,
    bus_source_encoder_if.slave bus
);

    localparam logic [IDX_W-1:0] RstIdx = IDX_W'(RESET_IDX);

    logic [N_SRC-1:0] req_s;
    logic             prio_s;

    // Optional input stage; req and prio_mode travel together so a request is
    // always judged under the mode it was issued with.
    if (STAGES == 2) begin : g_in_stage
        logic [N_SRC-1:0] req_q;
        logic             prio_q;

        always_ff @(posedge clk) begin
            if (clr) begin
                req_q  <= '0;
                prio_q <= 1'b0;
            end else begin
                req_q  <= bus.req;
                prio_q <= bus.prio_mode;
            end
        end

        assign req_s  = req_q;
        assign prio_s = prio_q;
    end else begin : g_no_stage
        assign req_s  = bus.req;
        assign prio_s = bus.prio_mode;
    end

    logic [IDX_W-1:0] lsb_idx;
    req_class_e       req_class;

    lsb_index_finder #(
        .N_SRC (N_SRC),
        .IDX_W (IDX_W)
    ) u_finder (
        .req       (req_s),
        .lsb_idx   (lsb_idx),
        .req_class (req_class)
    );

    enc_state_e           st_q, st_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 multi_err_q, multi_err_d;
    logic                 err_sticky_q, err_sticky_d;
    logic [ERR_CNT_W-1:0] err_count_q, err_count_d;
    logic                 accept;
    logic                 strict_multi;

    always_comb begin
        st_d         = st_q;
        idx_d        = idx_q;
        multi_err_d  = 1'b0;
        err_sticky_d = err_sticky_q;
        err_count_d  = err_count_q;

        accept       = (req_class == ClsOne) || ((req_class == ClsMulti) && prio_s);
        strict_multi = (req_class == ClsMulti) && !prio_s;

        if (accept) begin
            st_d  = StDrive;
            idx_d = lsb_idx;
        end else if (st_q != StEmpty) begin
            // Zero or strict multi-drive: keep the last good index.
            st_d = StHold;
        end

        // A fresh error outranks a simultaneous clear, so it counts as the first.
        if (strict_multi) begin
            multi_err_d  = 1'b1;
            err_sticky_d = 1'b1;
            err_count_d  = bus.err_clr ? ERR_CNT_W'(1) : err_cnt_inc(err_count_q);
        end else if (bus.err_clr) begin
            err_sticky_d = 1'b0;
            err_count_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            st_q         <= StEmpty;
            idx_q        <= RstIdx;
            multi_err_q  <= 1'b0;
            err_sticky_q <= 1'b0;
            err_count_q  <= '0;
        end else begin
            st_q         <= st_d;
            idx_q        <= idx_d;
            multi_err_q  <= multi_err_d;
            err_sticky_q <= err_sticky_d;
            err_count_q  <= err_count_d;
        end
    end

    assign bus.idx        = idx_q;
    assign bus.valid      = (st_q == StDrive);
    assign bus.hold       = (st_q == StHold);
    assign bus.multi_err  = multi_err_q;
    assign bus.err_sticky = err_sticky_q;
    assign bus.err_count  = err_count_q;

endmodule

// File: tb/tb_bus_source_encoder.sv
module tb_bus_source_encoder;

    logic clk = 1'b0;
    logic clr;
    always #5 clk = ~clk;

    bus_source_encoder_if #(.N_SRC(32)) ifa ();
    bus_source_encoder_if #(.N_SRC(32)) ifb ();
    bus_source_encoder_if #(.N_SRC(8))  ifc ();

    bus_source_encoder #(.N_SRC(32), .STAGES(1), .RESET_IDX(0)) dut_a (
        .clk (clk), .clr (clr), .bus (ifa)
    );
    bus_source_encoder #(.N_SRC(32), .STAGES(2), .RESET_IDX(0)) dut_b (
        .clk (clk), .clr (clr), .bus (ifb)
    );
    bus_source_encoder #(.N_SRC(8), .STAGES(1), .RESET_IDX(0)) dut_c (
        .clk (clk), .clr (clr), .bus (ifc)
    );

    // Observable encoder status as the rules define it.
    typedef struct {
        int idx;
        bit valid;
        bit hold;
        bit merr;
        bit sticky;
        int cnt;
    } mstate_t;

    mstate_t     m1, m2, m3;
    logic [31:0] stg_req;
    bit          stg_prio;
    int          total = 0;
    int          bad   = 0;
    bit          check_en = 1'b0;

    function automatic mstate_t mreset();
        mstate_t s;
        s.idx = 0; s.valid = 0; s.hold = 0; s.merr = 0; s.sticky = 0; s.cnt = 0;
        return s;
    endfunction

    function automatic mstate_t mstep(mstate_t s, logic [31:0] r, bit p, bit ec, int n);
        mstate_t     ns;
        logic [31:0] m;
        int          c;
        int          lo;
        ns = s;
        m  = (n >= 32) ? r : (r & ((32'd1 << n) - 32'd1));
        c  = $countones(m);
        lo = 0;
        for (int k = n - 1; k >= 0; k--) if (m[k]) lo = k;
        ns.merr = 0;
        if (c == 1 || (c > 1 && p)) begin
            ns.idx = lo; ns.valid = 1; ns.hold = 0;
        end else if (s.valid || s.hold) begin
            ns.valid = 0; ns.hold = 1;
        end
        if (c > 1 && !p) begin
            ns.merr   = 1;
            ns.sticky = 1;
            ns.cnt    = ec ? 1 : ((s.cnt < 255) ? s.cnt + 1 : 255);
        end else if (ec) begin
            ns.sticky = 0;
            ns.cnt    = 0;
        end
        return ns;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step_all(input logic [31:0] r, input bit p, input bit ec, input bit c);
        @(negedge clk);
        ifa.req = r;       ifa.prio_mode = p; ifa.err_clr = ec;
        ifb.req = r;       ifb.prio_mode = p; ifb.err_clr = ec;
        ifc.req = r[7:0];  ifc.prio_mode = p; ifc.err_clr = ec;
        clr = c;
        @(posedge clk);
        if (c) begin
            m1 = mreset(); m2 = mreset(); m3 = mreset();
            stg_req = '0; stg_prio = 0;
        end else begin
            m1 = mstep(m1, r, p, ec, 32);
            m3 = mstep(m3, r, p, ec, 8);
            m2 = mstep(m2, stg_req, stg_prio, ec, 32);
            stg_req  = r;
            stg_prio = p;
        end
        #1;
        check_en = 1'b1;
    endtask

    // Model comparison on every cycle, half a period after the update edge.
    always @(negedge clk) begin
        if (check_en) begin
            chk("a.idx",    32'(ifa.idx),        m1.idx);
            chk("a.valid",  32'(ifa.valid),      m1.valid);
            chk("a.hold",   32'(ifa.hold),       m1.hold);
            chk("a.merr",   32'(ifa.multi_err),  m1.merr);
            chk("a.sticky", 32'(ifa.err_sticky), m1.sticky);
            chk("a.cnt",    32'(ifa.err_count),  m1.cnt);
            chk("b.idx",    32'(ifb.idx),        m2.idx);
            chk("b.valid",  32'(ifb.valid),      m2.valid);
            chk("b.hold",   32'(ifb.hold),       m2.hold);
            chk("b.merr",   32'(ifb.multi_err),  m2.merr);
            chk("b.sticky", 32'(ifb.err_sticky), m2.sticky);
            chk("b.cnt",    32'(ifb.err_count),  m2.cnt);
            chk("c.idx",    32'(ifc.idx),        m3.idx);
            chk("c.valid",  32'(ifc.valid),      m3.valid);
            chk("c.hold",   32'(ifc.hold),       m3.hold);
            chk("c.merr",   32'(ifc.multi_err),  m3.merr);
            chk("c.sticky", 32'(ifc.err_sticky), m3.sticky);
            chk("c.cnt",    32'(ifc.err_count),  m3.cnt);
        end
    end

    function automatic logic [31:0] rand_req();
        int unsigned k;
        int unsigned hi;
        int unsigned a;
        int unsigned b;
        k  = $urandom_range(0, 9);
        hi = ($urandom_range(0, 1) == 0) ? 7 : 31;
        a  = $urandom_range(0, hi);
        b  = (a + $urandom_range(1, hi)) % (hi + 1);
        if (k < 2) return 32'd0;
        if (k < 6) return 32'd1 << a;
        if (k < 9) return (32'd1 << a) | (32'd1 << b);
        return $urandom;
    endfunction

    initial begin
        clr = 1'b1;
        ifa.req = '0; ifa.prio_mode = 0; ifa.err_clr = 0;
        ifb.req = '0; ifb.prio_mode = 0; ifb.err_clr = 0;
        ifc.req = '0; ifc.prio_mode = 0; ifc.err_clr = 0;

        step_all(32'h0, 0, 0, 1);
        step_all(32'h0, 0, 0, 1);
        chk("rst.idx",   32'(ifa.idx), 0);
        chk("rst.valid", 32'(ifa.valid), 0);
        chk("rst.cnt",   32'(ifa.err_count), 0);
        repeat (3) step_all(32'h0, 0, 0, 0);
        chk("idle.idx",   32'(ifa.idx), 0);
        chk("idle.valid", 32'(ifa.valid), 0);
        chk("idle.hold",  32'(ifa.hold), 0);

        step_all(32'h0002_0000, 0, 0, 0);
        chk("one17.idx",   32'(ifa.idx), 17);
        chk("one17.valid", 32'(ifa.valid), 1);
        step_all(32'h0, 0, 0, 0);
        chk("hold17.idx",  32'(ifa.idx), 17);
        chk("hold17.valid", 32'(ifa.valid), 0);
        chk("hold17.hold", 32'(ifa.hold), 1);
        step_all(32'h0000_8000, 0, 0, 0);
        chk("one15.idx",   32'(ifa.idx), 15);
        chk("one15.valid", 32'(ifa.valid), 1);

        step_all(32'h0000_0008, 0, 0, 0);
        chk("one3.idx", 32'(ifa.idx), 3);
        step_all(32'h0000_0011, 0, 0, 0);
        chk("smulti.idx",    32'(ifa.idx), 3);
        chk("smulti.hold",   32'(ifa.hold), 1);
        chk("smulti.merr",   32'(ifa.multi_err), 1);
        chk("smulti.sticky", 32'(ifa.err_sticky), 1);
        chk("smulti.cnt",    32'(ifa.err_count), 1);
        repeat (299) step_all(32'h0000_0011, 0, 0, 0);
        chk("sat.cnt", 32'(ifa.err_count), 255);

        step_all(32'h0400_0010, 1, 0, 0);
        chk("prio.idx",   32'(ifa.idx), 4);
        chk("prio.valid", 32'(ifa.valid), 1);
        chk("prio.merr",  32'(ifa.multi_err), 0);
        step_all(32'h0400_0010, 0, 1, 0);
        chk("errwins.cnt",    32'(ifa.err_count), 1);
        chk("errwins.sticky", 32'(ifa.err_sticky), 1);
        step_all(32'h0, 0, 1, 0);
        chk("eclr.cnt",    32'(ifa.err_count), 0);
        chk("eclr.sticky", 32'(ifa.err_sticky), 0);

        step_all(32'h0100_0000, 0, 0, 0);
        step_all(32'h0000_0001, 0, 0, 0);
        chk("s2.idx",   32'(ifb.idx), 24);
        chk("s2.valid", 32'(ifb.valid), 1);
        step_all(32'h0, 0, 0, 1);
        chk("s2clr.idx",   32'(ifb.idx), 0);
        chk("s2clr.valid", 32'(ifb.valid), 0);
        chk("s2clr.hold",  32'(ifb.hold), 0);
        repeat (2) step_all(32'h0, 0, 0, 0);
        chk("s2flush.idx",   32'(ifb.idx), 0);
        chk("s2flush.valid", 32'(ifb.valid), 0);
        chk("s2flush.hold",  32'(ifb.hold), 0);

        step_all(32'h0000_0080, 0, 0, 0);
        chk("n8.idx",   32'(ifc.idx), 7);
        chk("n8.valid", 32'(ifc.valid), 1);

        for (int i = 0; i < 3000; i++) begin
            step_all(rand_req(), ($urandom_range(0, 9) < 3), ($urandom_range(0, 9) == 0),
                     ($urandom_range(0, 49) == 0));
        end

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bus_source_encoder.md
# bus_source_encoder

Parametrised, registered source-select encoder for the datapath bus. Converts a vector of per-source drive requests (general registers plus special registers such as HI, LO, Zhigh, Zlow, PC, MDR, InPort, C) into the binary select index that steers the bus multiplexer. Adds what a bare one-hot encoder lacks:
- explicit valid/hold status
- strict or priority arbitration mode
- multi-drive error detection with sticky flag and counter
- optional extra pipeline stage

## Interface
Parameters
- N_SRC, 32, number of request lines; index = bit position.
- IDX_W, $clog2(N_SRC), derived; select index width.
- STAGES, 1, request-to-output latency in clock edges; legal values 1 or 2.
- RESET_IDX, 0, idx value after reset.

Ports
- clk  in  1  system clock; all state updates on rising edge.
- clr  in  1  reset; synchronous, active-high.
- req  in  N_SRC  drive requests; bit k set = source k wants the bus.
- prio_mode  in  1  0 = strict (exactly one-hot required), 1 = lowest-index-wins.
- err_clr  in  1  clears err_sticky and err_count.
- idx  out  IDX_W  registered bus select.
- valid  out  1  idx reflects a legal request from this update.
- hold  out  1  idx is being retained from an earlier update.
- multi_err  out  1  one-cycle pulse on a strict-mode multi-drive.
- err_sticky  out  1  set by any multi_err; cleared by clr or err_clr.
- err_count  out  8  saturating count of multi_err events.

## Operation
- Popcount of sampled req classifies the input: ZERO, ONE, MULTI.
- Sampled prio_mode and req travel together through the pipeline.
- State machine, register st:
  - EMPTY
    - Entered on reset.
    - valid=0, hold=0, idx=RESET_IDX.
  - DRIVE
    - Entered on ONE in either mode, or on MULTI in priority mode.
    - idx = position of the set bit, or the lowest set bit under priority.
    - valid=1, hold=0.
  - HOLD
    - Entered on ZERO from DRIVE or HOLD, and on strict MULTI from any state.
    - idx unchanged; valid=0, hold=1.
    - Exception: strict MULTI in EMPTY returns to EMPTY, with hold=0 and idx=RESET_IDX.
  - ZERO from EMPTY stays in EMPTY.
- Strict MULTI:
  - Never updates idx.
  - Pulses multi_err for one cycle.
  - Sets err_sticky.
  - Increments err_count, saturating at 255.
- Priority MULTI raises no error.
- Error clearing:
  - err_clr and a new strict MULTI in the same cycle: the error wins. err_sticky=1, err_count=1.
  - err_clr alone: err_sticky=0, err_count=0.
- clr overrides everything:
  - All outputs return to reset values in the cycle it is sampled.
  - The pipeline stage is flushed: its req is zeroed and prio_mode is set to 0.

## Timing
- STAGES=1: req sampled at edge k; idx/valid/hold/multi_err update at edge k.
- STAGES=2: req and prio_mode are registered at edge k; outputs update at edge k+1.
- Reset values: idx=RESET_IDX, valid=0, hold=0, multi_err=0, err_sticky=0, err_count=0, st=EMPTY.
- clr asserted mid-stream: the output after that edge is the reset value. The first request sampled after clr deasserts appears after the normal latency; with STAGES=2 the flushed stage emits nothing.
- No handshake with consumers. idx is guaranteed stable whenever valid=0 and hold=1.
- All outputs are registered; no combinational path from req to any output.

## Structure
- Shared package bus_enc_pkg:
  - state enum {EMPTY, DRIVE, HOLD}
  - class enum {ZERO, ONE, MULTI}
  - ERR_CNT_W = 8 and ERR_CNT_MAX = 255
- Sub-module lsb_index_finder, combinational:
  - Parameter N_SRC.
  - Outputs the lowest set-bit index and a 2-bit class (ZERO/ONE/MULTI).
  - Used for both strict and priority modes.
- Top level holds the optional input stage (generate on STAGES), the FSM, and the error counter.

## Test plan
All scenarios use N_SRC=32, STAGES=1 unless stated.
- Reset then req=0 for 3 cycles -> idx=0, valid=0, hold=0, st EMPTY.
- req=32'h0002_0000 -> next edge idx=17, valid=1. Then req=0 -> idx=17, valid=0, hold=1. Then req=32'h0000_8000 -> idx=15, valid=1.
- Strict mode, after idx=3, req=32'h0000_0011 -> idx stays 3, hold=1, multi_err pulses once, err_sticky=1, err_count=1. Repeat 300 cycles -> err_count=255.
- Priority mode, req=32'h0400_0010 -> idx=4, valid=1, multi_err=0. Same input with err_clr=1 and strict mode -> err_count=1, err_sticky=1.
- STAGES=2, req=32'h0100_0000 at edge k -> idx=24 at edge k+1. clr at edge k+2 with req=32'h1 pending -> reset values; idx=0 with valid=0 persists until a new request passes through the stage.
- N_SRC=8 build, req=8'h80 -> idx=7 (IDX_W=3), valid=1.
